// File: rtl/debug_frame_rx.sv
// debug_frame_rx: reassembles MSB-first byte frames ending in 0x0A; optional timeout via DEBUG_FRAME_RX_TIMEOUT_EN
module debug_frame_rx #(
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT_WIDTH = 20,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_TICKS = 20'd44000
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_pulse,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_error,
  output logic [7:0]            error_count,
  output logic                  busy
);
  localparam int N = DATA_WIDTH / 8;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);
  typedef enum logic [1:0] {IDLE, COLLECT, TERM} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_in, data_d;
  logic valid_d, err_d, expire;
  logic [7:0] ecnt_d, ecnt_inc;
  assign ecnt_inc = (error_count == 8'hFF) ? error_count : error_count + 8'd1;
  assign busy = state_q != IDLE;
  if (N == 1) begin : g_one
    assign shift_in = rx_data;
  end else begin : g_multi
    assign shift_in = {shift_q[DATA_WIDTH-9:0], rx_data};
  end
`ifdef DEBUG_FRAME_RX_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
  assign expire = !rx_pulse && state_q != IDLE && tmo_q + 1'b1 == TIMEOUT_TICKS;
  assign tmo_d = (rx_pulse || state_q == IDLE || expire) ? '0 : tmo_q + 1'b1;
  // inter-byte idle counter
  always_ff @(posedge clk_in) tmo_q <= reset ? '0 : tmo_d;
`else
  assign expire = 1'b0;
`endif
  // next-state, shift and strobe decode
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    data_d = data_out;
    valid_d = 1'b0;
    err_d = 1'b0;
    ecnt_d = error_count;
    if (rx_pulse) begin
      case (state_q)
        IDLE: begin
          shift_d = shift_in;
          cnt_d = CW'(1);
          state_d = (N == 1) ? TERM : COLLECT;
        end
        COLLECT: begin
          shift_d = shift_in;
          cnt_d = cnt_q + 1'b1;
          state_d = (cnt_d == LAST) ? TERM : COLLECT;
        end
        default: begin
          state_d = IDLE;
          valid_d = rx_data == 8'h0A;
          err_d = rx_data != 8'h0A;
          data_d = valid_d ? shift_q : data_out;
          ecnt_d = err_d ? ecnt_inc : error_count;
        end
      endcase
    end
    if (expire) begin
      state_d = IDLE;
      err_d = 1'b1;
      ecnt_d = ecnt_inc;
    end
  end
  // state and output registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      shift_q <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      frame_error <= 1'b0;
      error_count <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      data_out <= data_d;
      data_valid <= valid_d;
      frame_error <= err_d;
      error_count <= ecnt_d;
    end
  end
endmodule

// File: tb/tb_debug_frame_rx.sv
// tb_debug_frame_rx: table-driven frames with a strobe scoreboard for debug_frame_rx
module tb_debug_frame_rx;
  logic clk_in = 1'b0, reset = 1'b1, rx_pulse = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [15:0] data_out;
  logic data_valid, frame_error, busy;
  logic [7:0] error_count;
  int checks = 0, failures = 0, ncyc = 0;
  typedef struct {
    logic [7:0] b0, b1, b2;
    logic kind;
    logic [15:0] data;
    logic [7:0] ecnt;
  } vec_t;
  typedef struct {
    logic kind;
    logic [15:0] data;
    logic [7:0] ecnt;
    int at;
  } exp_t;
  exp_t q[$];
  vec_t tbl[6];
  debug_frame_rx #(.DATA_WIDTH(16), .TIMEOUT_WIDTH(20), .TIMEOUT_TICKS(20'd100)) dut (
    .clk_in(clk_in), .reset(reset), .rx_data(rx_data), .rx_pulse(rx_pulse),
    .data_out(data_out), .data_valid(data_valid), .frame_error(frame_error),
    .error_count(error_count), .busy(busy)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, x);
    end
  endtask
  // scoreboard: every strobe must match the oldest expectation, including its cycle
  always @(negedge clk_in) begin
    exp_t e;
    ncyc++;
    if (data_valid && frame_error) chk("both_strobes", 1, 0);
    if (data_valid || frame_error) begin
      if (q.size() == 0) chk("unexpected_strobe", {data_valid, frame_error}, 0);
      else begin
        e = q.pop_front();
        chk("strobe_kind", {data_valid, frame_error}, {e.kind, !e.kind});
        chk("strobe_data", data_out, e.data);
        chk("strobe_ecnt", error_count, e.ecnt);
        chk("strobe_cycle", ncyc, e.at);
      end
    end
  end
  task automatic send(input logic [7:0] b, input bit push, input exp_t e, input int lat);
    @(posedge clk_in);
    #1;
    if (push) begin
      e.at = ncyc + lat;
      q.push_back(e);
    end
    rx_data = b;
    rx_pulse = 1'b1;
    @(posedge clk_in);
    #1 rx_pulse = 1'b0;
    repeat (8) @(posedge clk_in);
  endtask
  task automatic send_frame(input vec_t v);
    exp_t e;
    e = '{v.kind, v.data, v.ecnt, 0};
    send(v.b0, 1'b0, e, 0);
    chk("busy_mid", busy, 1);
    send(v.b1, 1'b0, e, 0);
    chk("busy_mid2", busy, 1);
    send(v.b2, 1'b1, e, 2);
    chk("busy_end", busy, 0);
    chk("data_after", data_out, v.data);
    chk("ecnt_after", error_count, v.ecnt);
  endtask
  initial begin
    exp_t e;
    vec_t v;
    tbl[0] = '{8'hAB, 8'hCD, 8'h0A, 1'b1, 16'hABCD, 8'd0};
    tbl[1] = '{8'h12, 8'h34, 8'h55, 1'b0, 16'hABCD, 8'd1};
    tbl[2] = '{8'h0A, 8'h0A, 8'h0A, 1'b1, 16'h0A0A, 8'd1};
    tbl[3] = '{8'h00, 8'h0A, 8'h0A, 1'b1, 16'h000A, 8'd1};
    tbl[4] = '{8'hFF, 8'h00, 8'h0B, 1'b0, 16'h000A, 8'd2};
    tbl[5] = '{8'h80, 8'h01, 8'h0A, 1'b1, 16'h8001, 8'd2};
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_data", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_err", frame_error, 0);
    chk("rst_ecnt", error_count, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) send_frame(tbl[i]);
`ifdef DEBUG_FRAME_RX_TIMEOUT_EN
    e = '{1'b0, 16'h8001, 8'd3, 0};
    send(8'h12, 1'b1, e, 102);
    repeat (142) @(posedge clk_in);
    #1;
    chk("tmo_busy", busy, 0);
    chk("tmo_data", data_out, 16'h8001);
    send_frame('{8'h56, 8'h78, 8'h0A, 1'b1, 16'h5678, 8'd3});
`endif
    send(8'h12, 1'b0, e, 0);
    chk("pre_rst_busy", busy, 1);
    @(posedge clk_in);
    #1 reset = 1'b1;
    @(posedge clk_in);
    #1;
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_ecnt", error_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", frame_error, 0);
    reset = 1'b0;
    send_frame('{8'h9A, 8'hBC, 8'h0A, 1'b1, 16'h9ABC, 8'd0});
    for (int i = 0; i < 260; i++) begin
      v = '{8'h00, 8'h00, 8'hFF, 1'b0, 16'h9ABC, (i >= 254) ? 8'hFF : 8'(i + 1)};
      send_frame(v);
    end
    repeat (20) @(posedge clk_in);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
